// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row scan, frame classification, debounce FSM,
// and one event per press (digit handshake or single-cycle operator/equal pulse).
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       nRST,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    input  logic       key_read,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input
);
    localparam int             DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DF       = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [2:0] {IDLE, CONFIRM, PRESENT, WAIT_ACK, RELEASE} state_t;

    logic [3:0]    col_meta, col_sync;
    logic [DW-1:0] div_cnt;
    logic [1:0]    row_idx;
    logic          slot_end, frame_end;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (row_idx == 2'd3);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            div_cnt <= '0;
            row_idx <= 2'd0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) row_idx <= row_idx + 2'd1;
        end
    end

    assign row_out = ~(4'b0001 << row_idx);

    // Per-frame accumulation: hit count saturates at 2 (enough to tell MULTI).
    logic [2:0] row_hits, hits_tot;
    logic [1:0] row_col, hits_acc;
    logic [3:0] code_acc, code_tot;
    logic       frame_single;

    always_comb begin
        row_hits = '0;
        row_col  = '0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync[c]) begin
                row_hits = row_hits + 3'd1;
                row_col  = 2'(c);
            end
        end
        hits_tot     = {1'b0, hits_acc} + row_hits;
        code_tot     = (hits_acc == 2'd0) ? {row_idx, row_col} : code_acc;
        frame_single = (hits_tot == 3'd1);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            hits_acc <= '0;
            code_acc <= '0;
        end else if (slot_end) begin
            if (row_idx == 2'd3) begin
                hits_acc <= '0;
                code_acc <= '0;
            end else begin
                hits_acc <= (hits_tot >= 3'd2) ? 2'd2 : hits_tot[1:0];
                code_acc <= code_tot;
            end
        end
    end

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, code_q, code_d;
    logic       is_digit, is_eq;
    logic [3:0] digit_val;
    logic [2:0] op_code;

    always_comb begin
        is_digit  = 1'b0;
        is_eq     = 1'b0;
        digit_val = 4'd0;
        op_code   = 3'd0;
        case (code_q)
            4'd0:  begin is_digit = 1'b1; digit_val = 4'd1; end
            4'd1:  begin is_digit = 1'b1; digit_val = 4'd2; end
            4'd2:  begin is_digit = 1'b1; digit_val = 4'd3; end
            4'd3:  op_code = 3'd2;
            4'd4:  begin is_digit = 1'b1; digit_val = 4'd4; end
            4'd5:  begin is_digit = 1'b1; digit_val = 4'd5; end
            4'd6:  begin is_digit = 1'b1; digit_val = 4'd6; end
            4'd7:  op_code = 3'd3;
            4'd8:  begin is_digit = 1'b1; digit_val = 4'd7; end
            4'd9:  begin is_digit = 1'b1; digit_val = 4'd8; end
            4'd10: begin is_digit = 1'b1; digit_val = 4'd9; end
            4'd11: op_code = 3'd4;
            4'd12: op_code = 3'd1;
            4'd13: begin is_digit = 1'b1; digit_val = 4'd0; end
            4'd14: is_eq = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Outputs are decoded from state so reset clears them asynchronously.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        code_d         = code_q;
        read_input     = 1'b0;
        keypad_input   = 4'd0;
        operator_input = 3'd0;
        equal_input    = 1'b0;
        case (state_q)
            IDLE: if (frame_end && frame_single) begin
                code_d  = code_tot;
                cnt_d   = 4'd1;
                state_d = (DF == 4'd1) ? PRESENT : CONFIRM;
            end
            CONFIRM: if (frame_end) begin
                if (frame_single && code_tot == code_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DF) state_d = PRESENT;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                cnt_d = 4'd0;
                if (is_digit) begin
                    // A still-high ack belongs to the previous key; wait it out.
                    if (!key_read) begin
                        read_input   = 1'b1;
                        keypad_input = digit_val;
                        state_d      = WAIT_ACK;
                    end
                end else begin
                    operator_input = op_code;
                    equal_input    = is_eq;
                    state_d        = RELEASE;
                end
            end
            WAIT_ACK: begin
                read_input   = 1'b1;
                keypad_input = digit_val;
                if (key_read) begin
                    cnt_d   = 4'd0;
                    state_d = RELEASE;
                end
            end
            RELEASE: if (frame_end) begin
                if (frame_single) cnt_d = 4'd0;
                else if (cnt_q + 4'd1 == DF) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else cnt_d = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, event monitor, key-table vectors,
// randomized presses against a key-map model, and directed multi-cycle sequences.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DF = 2;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] row_out, col_in, keypad_input;
    logic       key_read = 1'b0;
    logic       read_input, equal_input;
    logic [2:0] operator_input;

    logic [15:0] pressed = '0;
    bit          auto_ack = 1'b1;
    logic        manual_ack = 1'b0;
    int          tests = 0, fails = 0, cyc = 0, last_fall = 0;

    typedef struct { int kind; int val; int t; } ev_t;   // kind 0 digit, 1 operator, 2 equal
    typedef struct { logic [15:0] keys; int kind; int val; } vec_t;
    ev_t  evq[$];
    vec_t tbl[18];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk), .nRST(nRST), .row_out(row_out), .col_in(col_in),
        .key_read(key_read), .keypad_input(keypad_input), .read_input(read_input),
        .operator_input(operator_input), .equal_input(equal_input)
    );

    always #5 clk = ~clk;

    // Matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Controller-side ack: registers read_input one cycle later, or a forced level.
    logic rd_n = 1'b0;
    always begin
        @(negedge clk);
        rd_n = read_input;
        @(posedge clk);
        #1;
        key_read = auto_ack ? rd_n : manual_ack;
    end

    logic       rd_prev = 1'b0;
    logic [3:0] kp_prev = 4'd0;
    logic [2:0] op_prev = 3'd0;
    always @(negedge clk) begin
        cyc++;
        if (!nRST) begin
            rd_prev = 1'b0;
            op_prev = 3'd0;
        end else begin
            if (read_input && !rd_prev) evq.push_back('{0, int'(keypad_input), cyc});
            if (!read_input && rd_prev) last_fall = cyc;
            if (read_input && rd_prev) check("kp_stable", keypad_input, kp_prev);
            if (operator_input != 3'd0) evq.push_back('{1, int'(operator_input), cyc});
            if (equal_input) evq.push_back('{2, 0, cyc});
            check("op_one_cycle", (operator_input != 3'd0) && (op_prev != 3'd0), 0);
            check("excl", (read_input && (operator_input != 3'd0 || equal_input)) ||
                          (operator_input != 3'd0 && equal_input), 0);
            rd_prev = read_input;
            kp_prev = keypad_input;
            op_prev = operator_input;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_ev(input int n, input int maxc);
        int k = 0;
        while (evq.size() < n && k < maxc) begin @(posedge clk); #1; k++; end
    endtask

    // Returns at the mid-point of the first cycle of a frame (row 0 just driven).
    task automatic align();
        logic [3:0] prev;
        int k = 0;
        @(negedge clk);
        prev = row_out;
        @(negedge clk);
        while (k < 40 && !(prev == 4'b0111 && row_out == 4'b1110)) begin
            prev = row_out;
            @(negedge clk);
            k++;
        end
        #1;
        check("align", k < 40, 1);
    endtask

    // Key map from the key layout: rows 0-2 hold digits r*3+c+1 and an operator.
    function automatic void model(input int k, output int kind, output int val);
        int r = k / 4, c = k % 4;
        kind = -1; val = 0;
        if (r < 3 && c < 3) begin kind = 0; val = r * 3 + c + 1; end
        else if (r < 3)     begin kind = 1; val = r + 2; end
        else if (c == 0)    begin kind = 1; val = 1; end
        else if (c == 1)    begin kind = 0; val = 0; end
        else if (c == 2)    begin kind = 2; val = 0; end
    endfunction

    task automatic expect_one(input string name, input int kind, input int val);
        check({name, "_count"}, evq.size(), (kind < 0) ? 0 : 1);
        if (kind >= 0 && evq.size() > 0) begin
            check({name, "_kind"}, evq[0].kind, kind);
            check({name, "_val"}, evq[0].val, val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, bad, kind, val, k, k2;
        logic [15:0] keys;
        tbl = '{
            '{16'h0001, 0, 1}, '{16'h0002, 0, 2}, '{16'h0004, 0, 3}, '{16'h0008, 1, 2},
            '{16'h0010, 0, 4}, '{16'h0020, 0, 5}, '{16'h0040, 0, 6}, '{16'h0080, 1, 3},
            '{16'h0100, 0, 7}, '{16'h0200, 0, 8}, '{16'h0400, 0, 9}, '{16'h0800, 1, 4},
            '{16'h1000, 1, 1}, '{16'h2000, 0, 0}, '{16'h4000, 2, 0}, '{16'h8000, -1, 0},
            '{16'h0021, -1, 0}, '{16'h8001, -1, 0}
        };

        tick(3);
        check("reset_outs", {row_out, read_input, keypad_input, operator_input, equal_input}, 13'b1110_0_0000_000_0);
        nRST = 1'b1;
        tick(5);

        foreach (tbl[i]) begin
            evq.delete();
            pressed = tbl[i].keys;
            tick(70);
            pressed = '0;
            tick(70);
            expect_one($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].val);
        end

        // Digit 7 pressed at a frame start; auto-ack; held with no repeat.
        align();
        evq.delete();
        pressed = 16'h0100;
        t0 = cyc;
        wait_ev(1, 60);
        tick(5);
        expect_one("t1", 0, 7);
        if (evq.size() > 0) begin
            check_rng("t1_latency", evq[0].t - t0, 31, 34);
            check("t1_drop", last_fall - evq[0].t, 2);
        end
        tick(200);
        check("t1_no_repeat", evq.size(), 1);
        pressed = '0;
        tick(70);

        // Bouncing "+": six 10-cycle segments, then held.
        align();
        evq.delete();
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0008 : 16'h0000;
            repeat (10) @(negedge clk);
        end
        check("t2_bounce_quiet", evq.size(), 0);
        pressed = 16'h0008;
        tick(100);
        expect_one("t2", 1, 2);
        pressed = '0;
        tick(70);

        // Negate then equal.
        evq.delete();
        pressed = 16'h1000; tick(70); pressed = '0; tick(70);
        pressed = 16'h4000; tick(70); pressed = '0; tick(70);
        check("t3_count", evq.size(), 2);
        if (evq.size() == 2) begin
            check("t3_neg", {evq[0].kind, evq[0].val}, {32'd1, 32'd1});
            check("t3_eq", evq[1].kind, 2);
        end

        // Two keys held: nothing; then releasing "5" leaves a clean "1".
        evq.delete();
        pressed = 16'h0021;
        tick(100);
        check("t4_multi_quiet", evq.size(), 0);
        pressed = 16'h0001;
        t0 = cyc;
        wait_ev(1, 60);
        tick(5);
        expect_one("t4", 0, 1);
        if (evq.size() > 0) check_rng("t4_latency", evq[0].t - t0, 1, 55);
        pressed = '0;
        tick(70);

        // Stale ack blocks presentation; stalled ack holds the digit.
        auto_ack = 1'b0;
        manual_ack = 1'b1;
        tick(2);
        evq.delete();
        pressed = 16'h2000;
        tick(80);
        check("t5_stale_rd", read_input, 0);
        check("t5_stale_count", evq.size(), 0);
        manual_ack = 1'b0;
        wait_ev(1, 10);
        expect_one("t5", 0, 0);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (read_input !== 1'b1 || keypad_input !== 4'd0) bad++;
        end
        check("t5_hold_bad_cycles", bad, 0);
        #1;
        manual_ack = 1'b1;
        tick(5);
        check("t5_acked_rd", read_input, 0);
        pressed = '0;
        tick(70);
        manual_ack = 1'b0;
        tick(3);

        // Reset during WAIT_ACK, key kept held.
        evq.delete();
        pressed = 16'h2000;
        wait_ev(1, 60);
        tick(3);
        check("t6_waiting", read_input, 1);
        nRST = 1'b0;
        #1;
        check("t6_reset_outs", {row_out, read_input, keypad_input, operator_input, equal_input}, 13'b1110_0_0000_000_0);
        tick(3);
        evq.delete();
        nRST = 1'b1;
        t0 = cyc;
        tick(60);
        expect_one("t6", 0, 0);
        if (evq.size() > 0) check_rng("t6_latency", evq[0].t - t0, 31, 36);
        manual_ack = 1'b1;
        tick(3);
        pressed = '0;
        tick(70);
        manual_ack = 1'b0;
        auto_ack = 1'b1;
        tick(3);

        // Random single and double presses against the key-map model.
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 15);
            keys = 16'(1) << k;
            model(k, kind, val);
            if ($urandom_range(0, 4) == 0) begin
                k2 = (k + $urandom_range(1, 15)) % 16;
                keys = keys | (16'(1) << k2);
                kind = -1;
            end
            tick($urandom_range(0, 15));
            evq.delete();
            pressed = keys;
            t0 = cyc;
            tick($urandom_range(60, 120));
            pressed = '0;
            tick($urandom_range(60, 100));
            expect_one($sformatf("rnd%0d", i), kind, val);
            if (kind >= 0 && evq.size() > 0) check_rng($sformatf("rnd%0d_latency", i), evq[0].t - t0, 1, 55);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
